// File: rtl/eb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eb_pkg
//  Description : Shared types and helpers for the elastic-buffer library:
//                arbiter state encoding and a grant-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package eb_pkg;

  // Arbiter state encoding (BURST is only reachable with EB_RR_ARB_LAST_EN)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_BURST = 2'b10
  } eb_arb_state_t;

  // Width of an index into N items; never narrower than one bit
  function automatic int eb_gw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : eb_rr_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                set request scanning base, base+1, ..., N-1, 0, ..., base-1.
//                With no request set, win returns base.
//  Revision    : 1.0 - initial release
// ============================================================================
module eb_rr_pick
  import eb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = eb_gw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] base,
  output logic [GW-1:0] win,
  output logic          any
);

  int   start;
  int   idx;
  logic found;

  // Scan the requests in rotated order and keep the first hit
  always_comb begin
    win   = base;
    any   = |req;
    found = 1'b0;
    idx   = 0;
    // An out-of-range base (non power-of-two N) falls back to index 0
    start = (int'(base) < N) ? int'(base) : 0;
    for (int j = 0; j < N; j++) begin
      idx = start + j;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : eb_rr_arb
//  Description : N-input round-robin arbiter merging N elastic req/ack
//                streams into one. Zero-latency forward path; a stall locks
//                the current winner until it transfers; the priority pointer
//                moves past each served stream.
//                Optional macro EB_RR_ARB_LAST_EN adds t_last/i_last ports
//                and a BURST state so packets never interleave.
//  Revision    : 1.0 - initial release
// ============================================================================
module eb_rr_arb
  import eb_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int GW = eb_gw(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] t_dat,
  input  logic [N-1:0]   t_req,
  output logic [N-1:0]   t_ack,
`ifdef EB_RR_ARB_LAST_EN
  input  logic [N-1:0]   t_last,
  output logic           i_last,
`endif
  output logic [W-1:0]   i_dat,
  output logic           i_req,
  input  logic           i_ack,
  output logic [GW-1:0]  i_gnt
);

  eb_arb_state_t state, state_nxt;
  logic [GW-1:0] ptr, ptr_nxt;
  logic [GW-1:0] gnt, gnt_nxt;

  logic [GW-1:0] win;
  logic          any;
  logic [GW-1:0] sel;
  logic          out_req;
  logic          beat_last;

  // Index following x, wrapping from N-1 back to 0
  function automatic logic [GW-1:0] ptr_inc(input logic [GW-1:0] x);
    if (int'(x) >= N - 1) return '0;
    return x + 1'b1;
  endfunction

  eb_rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req  (t_req),
    .base (ptr),
    .win  (win),
    .any  (any)
  );

  // Forward path: select the source, mux its data and steer the acknowledge
  always_comb begin
    sel     = (state == ST_IDLE) ? win : gnt;
    out_req = (state == ST_IDLE) ? any : t_req[gnt];
    i_dat   = '0;
    t_ack   = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == GW'(k)) begin
        i_dat    = t_dat[k*W +: W];
        t_ack[k] = i_ack & out_req;
      end
    end
    i_req = out_req;
    i_gnt = sel;
  end

`ifdef EB_RR_ARB_LAST_EN
  // Packet delimiter of the selected stream
  always_comb begin
    beat_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == GW'(k)) beat_last = t_last[k];
    end
    i_last = beat_last;
  end
`else
  assign beat_last = 1'b1;
`endif

  // Next-state logic: lock on stall or open packet, advance pointer on done
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    case (state)
      ST_IDLE: begin
        if (out_req) begin
          if (i_ack) begin
            if (beat_last) begin
              ptr_nxt = ptr_inc(sel);
            end else begin
              gnt_nxt   = sel;
              state_nxt = ST_BURST;
            end
          end else begin
            gnt_nxt   = sel;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A dropped request here is a producer error; release without transfer
        if (!t_req[gnt]) begin
          state_nxt = ST_IDLE;
        end else if (i_ack) begin
          if (beat_last) begin
            ptr_nxt   = ptr_inc(gnt);
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_BURST;
          end
        end
      end
`ifdef EB_RR_ARB_LAST_EN
      ST_BURST: begin
        // Gaps between beats keep the lock; only the last beat releases it
        if (out_req && i_ack && beat_last) begin
          ptr_nxt   = ptr_inc(gnt);
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer and grant registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
    end
  end

`ifndef SYNTHESIS
  // A locked producer must hold its request until acknowledged
  hold_req_stable : assert property (
    @(posedge clk) disable iff (!reset_n)
    (state == ST_HOLD) |-> t_req[gnt]
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_eb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eb_rr_arb
//  Description : Self-checking bench for eb_rr_arb (N=4/W=32 and N=1/W=8).
//                Covers EB_RR_ARB_LAST_EN packet locking when the macro is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eb_rr_arb;

  logic clk = 1'b0;
  logic reset_n;

  // N=4, W=32 instance
  logic [127:0] t_dat;
  logic [3:0]   t_req;
  logic [3:0]   t_ack;
  logic [31:0]  i_dat;
  logic         i_req;
  logic         i_ack;
  logic [1:0]   i_gnt;
`ifdef EB_RR_ARB_LAST_EN
  logic [3:0]   t_last;
  logic         i_last;
`endif

  // N=1, W=8 instance
  logic [7:0]   t1_dat;
  logic [0:0]   t1_req;
  logic [0:0]   t1_ack;
  logic [7:0]   i1_dat;
  logic         i1_req;
  logic         i1_ack;
  logic [0:0]   i1_gnt;
`ifdef EB_RR_ARB_LAST_EN
  logic [0:0]   t1_last;
  logic         i1_last;
`endif

  int tests = 0;
  int fails = 0;

  eb_rr_arb #(.W(32), .N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .t_dat   (t_dat),
    .t_req   (t_req),
    .t_ack   (t_ack),
`ifdef EB_RR_ARB_LAST_EN
    .t_last  (t_last),
    .i_last  (i_last),
`endif
    .i_dat   (i_dat),
    .i_req   (i_req),
    .i_ack   (i_ack),
    .i_gnt   (i_gnt)
  );

  eb_rr_arb #(.W(8), .N(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .t_dat   (t1_dat),
    .t_req   (t1_req),
    .t_ack   (t1_ack),
`ifdef EB_RR_ARB_LAST_EN
    .t_last  (t1_last),
    .i_last  (i1_last),
`endif
    .i_dat   (i1_dat),
    .i_req   (i1_req),
    .i_ack   (i1_ack),
    .i_gnt   (i1_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       exp_req;
    logic [3:0] exp_ack;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare all N=4 outputs against an expected grant/ack/req triple
  task automatic check4(input string tag, input logic er, input logic [3:0] ea, input logic [1:0] eg);
    logic [31:0] ed;
    ed = 32'h100 + 32'(eg);
    check({tag, ".i_req"}, 64'(i_req), 64'(er));
    check({tag, ".t_ack"}, 64'(t_ack), 64'(ea));
    check({tag, ".i_gnt"}, 64'(i_gnt), 64'(eg));
    check({tag, ".i_dat"}, 64'(i_dat), 64'(ed));
  endtask

  initial begin
    logic [7:0] tx_val;
    logic [7:0] rx_exp;
    logic       pending;
    int         sent;
    int         rcvd;

    reset_n = 1'b0;
    t_req   = '0;
    i_ack   = 1'b1;
    for (int k = 0; k < 4; k++) t_dat[k*32 +: 32] = 32'h100 + 32'(k);
    t1_dat  = '0;
    t1_req  = '0;
    i1_ack  = 1'b0;
`ifdef EB_RR_ARB_LAST_EN
    t_last  = '1;
    t1_last = '1;
`endif

    // Saturated rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{4'b1111, 1'b1, 1'b1, 4'(1 << (i % 4)), 2'(i % 4)};
    end
    tbl[8]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0}; // ptr -> 1
    tbl[9]  = '{4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2}; // stall locks stream 2
    tbl[10] = '{4'b0111, 1'b0, 1'b1, 4'b0000, 2'd2}; // stream 1 raised, ignored
    tbl[11] = '{4'b0111, 1'b0, 1'b1, 4'b0000, 2'd2};
    tbl[12] = '{4'b0111, 1'b1, 1'b1, 4'b0100, 2'd2}; // transfer, ptr -> 3
    tbl[13] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0}; // wraps past 3 to 0
    tbl[14] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1}; // then stream 1, ptr -> 2
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2}; // idle shows ptr
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2};
    tbl[17] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3}; // stall locks stream 3

    // Outputs while reset is held
    #1;
    check4("rst_hold", 1'b0, 4'b0000, 2'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check4("rst_rel", 1'b0, 4'b0000, 2'd0);

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      t_req = tbl[i].req;
      i_ack = tbl[i].ack;
      @(negedge clk);
      check4($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_ack, tbl[i].exp_gnt);
    end

    // HOLD on stream 3: a new request from stream 1 does not steal the grant
    @(posedge clk);
    #1 t_req = 4'b1010;
    i_ack = 1'b0;
    @(negedge clk);
    check4("hold3", 1'b1, 4'b0000, 2'd3);
    // Asynchronous reset mid-HOLD: pick restarts from ptr=0
    #2 reset_n = 1'b0;
    #1;
    check4("hold3_rst", 1'b1, 4'b0000, 2'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    i_ack = 1'b1;
    @(negedge clk);
    check4("post_rst", 1'b1, 4'b0010, 2'd1);
    @(posedge clk);
    #1 t_req = 4'b0000;
    @(negedge clk);
    check4("post_rst_idle", 1'b0, 4'b0000, 2'd2);

`ifdef EB_RR_ARB_LAST_EN
    // Three-beat packet on stream 0 with stream 1 waiting; ptr=2 picks 0
    @(posedge clk);
    #1 t_req = 4'b0011; t_last = 4'b1110; i_ack = 1'b1;
    @(negedge clk);
    check4("pkt_b1", 1'b1, 4'b0001, 2'd0);
    check("pkt_b1.i_last", 64'(i_last), 64'd0);
    @(posedge clk);
    #1 i_ack = 1'b0;
    @(negedge clk);
    check4("pkt_stall", 1'b1, 4'b0000, 2'd0);
    @(posedge clk);
    #1 i_ack = 1'b1;
    @(negedge clk);
    check4("pkt_b2", 1'b1, 4'b0001, 2'd0);
    @(posedge clk);
    #1 t_last = 4'b1111;
    @(negedge clk);
    check4("pkt_b3", 1'b1, 4'b0001, 2'd0);
    check("pkt_b3.i_last", 64'(i_last), 64'd1);
    @(posedge clk);
    #1 t_req = 4'b0010;
    @(negedge clk);
    check4("pkt_next", 1'b1, 4'b0010, 2'd1);
    @(posedge clk);
    #1 t_req = 4'b0000;
`endif

    // N=1 degenerate arbiter with random stalls and an in-order scoreboard
    tx_val  = 8'h10;
    rx_exp  = 8'h10;
    pending = 1'b0;
    sent    = 0;
    rcvd    = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (!pending) begin
        t1_req = 1'($urandom_range(0, 1));
        if (t1_req[0]) begin
          t1_dat  = tx_val;
          pending = 1'b1;
        end
      end
      i1_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("n1.i_dat", 64'(i1_dat), 64'(t1_dat));
      check("n1.t_ack", 64'(t1_ack), 64'(i1_ack & t1_req[0]));
      check("n1.i_req", 64'(i1_req), 64'(t1_req));
      check("n1.i_gnt", 64'(i1_gnt), 64'd0);
      if (i1_req && i1_ack) begin
        check("n1.order", 64'(i1_dat), 64'(rx_exp));
        rx_exp++;
        rcvd++;
      end
      if (t1_ack[0]) begin
        pending = 1'b0;
        tx_val++;
        sent++;
      end
    end
    check("n1.count", 64'(rcvd), 64'(sent));
    check("n1.progress", 64'(rcvd > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eb_rr_arb.md
Name: eb_rr_arb

Overview:
- N-input round-robin arbiter that merges N elastic req/ack streams into one elastic output stream.
- Sits upstream of an elastic buffer stage so several producers can share one buffered channel.
- Zero-latency combinational forward path.
- Sequential grant lock keeps the output stable while the consumer stalls; a rotating priority pointer gives fairness.

Parameters:
- W, 32, data width per stream.
- N, 4, number of input streams (N >= 1).
- GW, (N>1 ? $clog2(N) : 1), width of the grant index; derived, not to be overridden.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- t_dat  input  N*W  input data; stream k occupies bits [k*W +: W].
- t_req  input  N  per-stream request (data valid).
- t_ack  output  N  per-stream acknowledge; a beat transfers when t_req[k] & t_ack[k].
- i_dat  output  W  merged output data.
- i_req  output  1  output request.
- i_ack  input  1  output acknowledge from the downstream elastic buffer.
- i_gnt  output  GW  index of the stream currently driving i_dat.

Behaviour:
- Handshake rule, both sides:
  - A transfer occurs on a clk edge with req & ack high.
  - A producer holding req must keep req and dat stable until ack.
  - The block obeys the same rule on i_req/i_dat.
- Registers:
  - state: IDLE or HOLD.
  - ptr[GW]: highest-priority index.
  - gnt[GW]: locked winner.
  - Reset values: state=IDLE, ptr=0, gnt=0.
- Outputs during and after reset: i_req=0 unless some t_req is high; t_ack=0 whenever i_ack=0.
- Pick function: win = first k with t_req[k]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- IDLE:
  - sel=win. i_req=|t_req. i_dat=t_dat[sel], i_gnt=sel.
  - If i_req & i_ack: transfer; ptr<=(sel+1) mod N; stay IDLE.
  - If i_req & ~i_ack: gnt<=sel; go HOLD.
  - If no t_req: outputs i_req=0, i_gnt=ptr, i_dat=t_dat[ptr]; no register change.
- HOLD:
  - sel=gnt. i_req=t_req[gnt]. Other requests are ignored, even higher-priority ones.
  - On i_ack: transfer; ptr<=(gnt+1) mod N; go IDLE.
  - Otherwise stay HOLD.
- t_ack[k] = i_ack & i_req & (sel==k). All other t_ack bits are 0.
- Wrap-around: ptr increments from N-1 to 0.
- N=1: ptr and gnt stay 0; the block degenerates to a wire with a HOLD state.
- Simultaneous requests: exactly one is granted per transfer. With all inputs saturated, grants rotate 0,1,...,N-1,0.
- A producer dropping t_req in HOLD is a protocol violation. In simulation it fires an assertion; the RTL returns to IDLE on the next edge with no transfer.
- reset_n low mid-HOLD: immediate return to IDLE/ptr=0. No transfer is counted.

Optional Feature:
- Macro: EB_RR_ARB_LAST_EN.
- With the macro:
  - Extra ports t_last input N and i_last output 1, with i_last=t_last[sel].
  - Adds state BURST.
  - A transfer with t_last[sel]=0 locks gnt<=sel and enters BURST; ptr is unchanged.
  - BURST behaves like HOLD, but only a transfer with last=1 advances ptr and returns to IDLE. A stall on a last beat stays in BURST.
  - Packets from different streams never interleave.
- Without the macro: every beat is treated as last; there are no t_last/i_last ports and no BURST state.

Decomposition:
- Shared package eb_pkg:
  - Arbiter state encoding: IDLE=2'b00, HOLD=2'b01, BURST=2'b10.
  - A clog2-based width helper for GW.
- One natural sub-module, eb_rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[N], base[GW].
  - Outputs: win[GW], any.
  - Reusable by other schedulers in the elastic library.

Test Plan:
- Reset, then t_req=4'b0000 -> i_req=0, t_ack=0, i_gnt=0; after reset_n deasserts, state IDLE, ptr=0.
- t_req=4'b1111, i_ack=1 held 8 cycles, t_dat[k]=k -> i_gnt and i_dat sequence 0,1,2,3,0,1,2,3; each cycle exactly one t_ack bit high.
- ptr=1, t_req=4'b0101, i_ack=0 for 3 cycles then 1 -> i_gnt=2 held stable 4 cycles. During the stall, raise t_req[1]: grant must not change. Transfer of stream 2; next grant is stream 0 (ptr=3 wraps past the idle stream 3 to 0); stream 1 is served after stream 0.
- Assert reset_n=0 while in HOLD on stream 3 -> outputs drop immediately (i_req follows t_req via pick from ptr=0). No t_ack is issued for stream 3 before reset.
- With EB_RR_ARB_LAST_EN: stream 0 sends a 3-beat packet (last on beat 3) while stream 1 requests continuously, with a mid-packet i_ack stall -> i_gnt=0 for all 3 beats; stream 1 is granted only after the last beat transfers.
- N=1, W=8, random i_ack stalls -> i_dat equals t_dat and t_ack equals i_ack&t_req every cycle; the scoreboard sees no lost or duplicated beats.
